// File: rtl/addsub64_stage.sv
`default_nettype none
// ============================================================================
// addsub64_stage / adder64_wrapper: two-deep valid/ready add/subtract pipeline
// Rev 1.0
// ============================================================================

module adder64_wrapper (
  input  logic [63:0] op1,
  input  logic [63:0] op2,
  input  logic        carry_in,
  output logic [63:0] sum,
  output logic        carry_out
);
  assign {carry_out, sum} = {1'b0, op1} + {1'b0, op2} + {64'd0, carry_in};
endmodule

module addsub64_stage #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_op1,
  input  logic [63:0]      in_op2,
  input  logic             in_sub,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_valid;
  logic [63:0]      s1_a;
  logic [63:0]      s1_b_eff;
  logic             s1_cin_eff;
  logic             s1_sub;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic [63:0]      s2_result;
  logic             s2_carry;
  logic             s2_ovf;
  logic             s2_zero;
  logic             s2_neg;
  logic [TAG_W-1:0] s2_tag;

  logic        s2_free;
  logic        s1_adv;
  logic        s1_load;
  logic [63:0] sum;
  logic        carry_out;

  assign s2_free  = ~s2_valid | out_ready;
  assign s1_adv   = s1_valid & s2_free;
  assign in_ready = ~s1_valid | s2_free;
  assign s1_load  = in_valid & in_ready;

  adder64_wrapper u_adder (
    .op1       (s1_a),
    .op2       (s1_b_eff),
    .carry_in  (s1_cin_eff),
    .sum       (sum),
    .carry_out (carry_out)
  );

  // Subtraction is A + ~B + ~bin, so borrow-out is the inverted carry-out.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_a       <= 64'd0;
      s1_b_eff   <= 64'd0;
      s1_cin_eff <= 1'b0;
      s1_sub     <= 1'b0;
      s1_tag     <= '0;
      s2_valid   <= 1'b0;
      s2_result  <= 64'd0;
      s2_carry   <= 1'b0;
      s2_ovf     <= 1'b0;
      s2_zero    <= 1'b1;
      s2_neg     <= 1'b0;
      s2_tag     <= '0;
    end else begin
      if (s1_load) begin
        s1_valid   <= 1'b1;
        s1_a       <= in_op1;
        s1_b_eff   <= in_sub ? ~in_op2 : in_op2;
        s1_cin_eff <= in_sub ? ~in_cin : in_cin;
        s1_sub     <= in_sub;
        s1_tag     <= in_tag;
      end else if (s1_adv) begin
        s1_valid   <= 1'b0;
      end

      if (s1_adv) begin
        s2_valid  <= 1'b1;
        s2_result <= sum;
        s2_carry  <= s1_sub ? ~carry_out : carry_out;
        s2_ovf    <= (s1_a[63] == s1_b_eff[63]) && (sum[63] != s1_a[63]);
        s2_zero   <= (sum == 64'd0);
        s2_neg    <= sum[63];
        s2_tag    <= s1_tag;
      end else if (out_ready) begin
        s2_valid  <= 1'b0;
      end
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign out_carry  = s2_carry;
  assign out_ovf    = s2_ovf;
  assign out_zero   = s2_zero;
  assign out_neg    = s2_neg;
  assign out_tag    = s2_tag;

endmodule
`default_nettype wire
